// File: rtl/bus_pkg.sv
// Shared types and constants for the multiplexed-bus memory responder.
// Exports the FSM state enum, Rw encodings, bus width and window decode.
package bus_pkg;

    localparam int   BUS_W    = 8;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        ADDR,
        RLAT,
        RDRIVE,
        WDONE
    } bus_state_e;

    // 9-bit compare so a window ending at 8'hFF never wraps to 8'h00.
    function automatic logic in_window(
        input logic [BUS_W-1:0] a,
        input logic [BUS_W-1:0] base,
        input int               depth
    );
        logic [BUS_W:0] lo;
        logic [BUS_W:0] hi;
        lo = {1'b0, base};
        hi = lo + 9'(depth);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// DEPTH x 8 single-port byte RAM: synchronous write, registered read.
// Ports: clk, rst (clears read register), we, re, addr, wdata, rdata.
module bus_mem_array
    import bus_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] rdata
);

    logic [BUS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Target-side responder for the CPU's multiplexed 8-bit address/data bus.
// Ports: clk, rst, Bus_In, ALE, Rw, En in; Bus_Out, Bus_Oe, Busy, Hit out.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE    = 8'h00,
    parameter int         DEPTH        = 64,
    parameter int         READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] Bus_In,
    input  logic             ALE,
    input  logic             Rw,
    input  logic             En,
    output logic [BUS_W-1:0] Bus_Out,
    output logic [BUS_W-1:0] Bus_Oe,
    output logic             Busy,
    output logic             Hit
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 2;

    bus_state_e       state;
    bus_state_e       state_n;
    logic [AW-1:0]    clr_ptr;
    logic [BUS_W-1:0] addr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_n;
    logic [AW-1:0]    idx;

    logic             mem_we;
    logic             mem_re;
    logic [AW-1:0]    mem_addr;
    logic [BUS_W-1:0] mem_wdata;

    logic             rd_ok;

    // Offset into the RAM; window check already guarantees it is < DEPTH.
    assign idx   = AW'(addr_q - ADDR_BASE);
    assign rd_ok = En && (Rw == RW_READ);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = idx;
        mem_wdata = Bus_In;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clr_ptr;
            mem_wdata = '0;
            if (clr_ptr == AW'(DEPTH - 1)) begin
                state_n = IDLE;
            end
        end else if (ALE) begin
            state_n = ADDR;
        end else begin
            unique case (state)
                ADDR: begin
                    if (En) begin
                        if (!Hit) begin
                            state_n = WDONE;
                        end else if (Rw == RW_READ) begin
                            mem_re  = 1'b1;
                            cnt_n   = CW'(READ_LATENCY - 1);
                            state_n = (READ_LATENCY == 1) ? RDRIVE : RLAT;
                        end else begin
                            mem_we  = 1'b1;
                            state_n = WDONE;
                        end
                    end
                end
                RLAT: begin
                    if (!rd_ok) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_n = RDRIVE;
                        end
                    end
                end
                RDRIVE: begin
                    if (!rd_ok) begin
                        state_n = IDLE;
                    end
                end
                WDONE: begin
                    if (!En) begin
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            addr_q  <= '0;
            Hit     <= 1'b0;
            cnt_q   <= '0;
            Busy    <= 1'b1;
            Bus_Oe  <= '0;
        end else begin
            state <= state_n;
            cnt_q <= cnt_n;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (state != CLEAR && ALE) begin
                addr_q <= Bus_In;
                Hit    <= in_window(Bus_In, ADDR_BASE, DEPTH);
            end
            Busy   <= (state_n == CLEAR);
            // Drive only while the next state is RDRIVE, so a sampled
            // Rw=0, En=0 or ALE releases the bus on the same edge.
            Bus_Oe <= (state_n == RDRIVE) ? '1 : '0;
        end
    end

    bus_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (Bus_Out)
    );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed bus transactions
// plus randomized traffic against a transaction-level model.
module tb_bus_mem_responder;

    localparam logic [7:0] BASE  = 8'h40;
    localparam int         DEPTH = 64;
    localparam int         RL    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] Bus_In = 8'h00;
    logic       ALE = 1'b0;
    logic       Rw = 1'b1;
    logic       En = 1'b0;
    logic [7:0] Bus_Out;
    logic [7:0] Bus_Oe;
    logic       Busy;
    logic       Hit;

    int n_checks = 0;
    int n_pass   = 0;

    bus_mem_responder #(
        .ADDR_BASE    (BASE),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Bus_In  (Bus_In),
        .ALE     (ALE),
        .Rw      (Rw),
        .En      (En),
        .Bus_Out (Bus_Out),
        .Bus_Oe  (Bus_Oe),
        .Busy    (Busy),
        .Hit     (Hit)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Transaction-level model: memory by full bus address, a countdown
    // for the clear sweep, and a run length for the current read phase.
    logic [7:0] m_mem [256];
    int         m_sweep   = 0;
    bit         m_valid   = 0;
    bit         m_hit     = 0;
    logic [7:0] m_addr    = 8'h00;
    bit         m_open    = 0;
    bit         m_reading = 0;
    int         m_run     = 0;

    task automatic model_step(input bit s_rst, input bit s_ale,
                              input bit s_en, input bit s_rw,
                              input logic [7:0] s_bus);
        if (s_rst) begin
            m_valid   = 1;
            m_sweep   = DEPTH;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            m_hit     = 0;
            m_open    = 0;
            m_reading = 0;
            m_run     = 0;
        end else if (!m_valid) begin
            m_open = 0;
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else if (s_ale) begin
            m_addr    = s_bus;
            m_hit     = (int'(s_bus) >= int'(BASE)) &&
                        (int'(s_bus) < int'(BASE) + DEPTH);
            m_open    = 1;
            m_reading = 0;
        end else if (m_open) begin
            if (s_en) begin
                m_open = 0;
                if (m_hit && s_rw) begin
                    m_reading = 1;
                    m_run     = 1;
                end else if (m_hit) begin
                    m_mem[m_addr] = s_bus;
                end
            end
        end else if (m_reading) begin
            if (s_en && s_rw) m_run++;
            else m_reading = 0;
        end
    endtask

    initial begin
        bit         s_rst;
        bit         s_ale;
        bit         s_en;
        bit         s_rw;
        logic [7:0] s_bus;
        logic [7:0] e_oe;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_ale = ALE;
            s_en  = En;
            s_rw  = Rw;
            s_bus = Bus_In;
            model_step(s_rst, s_ale, s_en, s_rw, s_bus);
            @(negedge clk);
            if (m_valid) begin
                e_oe = (m_reading && m_run >= RL) ? 8'hFF : 8'h00;
                check8("m_busy", 8'(Busy), 8'(m_sweep > 0));
                check8("m_hit", 8'(Hit), 8'(m_hit));
                check8("m_oe", Bus_Oe, e_oe);
                if (e_oe == 8'hFF) check8("m_out", Bus_Out, m_mem[m_addr]);
            end
        end
    end

    task automatic drive(input bit ale, input bit en, input bit rw,
                         input logic [7:0] d);
        @(negedge clk);
        ALE    = ale;
        En     = en;
        Rw     = rw;
        Bus_In = d;
    endtask

    task automatic wait_sweep();
        int cnt;
        cnt = 0;
        while (Busy && cnt < 200) begin
            cnt++;
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        end
        check8("busy_cycles", 8'(cnt), 8'(DEPTH));
        drive(0, 0, 1, 8'h00);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        drive(1, 0, 1, a);
        drive(0, 1, 0, d);
        drive(0, 0, 1, 8'h00);
    endtask

    // Issues the read data phase and checks the exact drive latency.
    task automatic read_tail(input string name, input logic [7:0] exp);
        drive(0, 1, 1, 8'h00);
        for (int i = 1; i < RL; i++) begin
            drive(0, 1, 1, 8'h00);
            check8({name, "_early_oe"}, Bus_Oe, 8'h00);
        end
        drive(0, 0, 1, 8'h00);
        check8({name, "_oe"}, Bus_Oe, 8'hFF);
        check8({name, "_data"}, Bus_Out, exp);
        check8({name, "_hit"}, 8'(Hit), 8'h01);
        drive(0, 0, 1, 8'h00);
        check8({name, "_release"}, Bus_Oe, 8'h00);
    endtask

    task automatic do_read(input string name, input logic [7:0] a,
                           input logic [7:0] exp);
        drive(1, 0, 1, a);
        read_tail(name, exp);
    endtask

    task automatic do_miss(input logic [7:0] a);
        drive(1, 0, 1, a);
        drive(0, 1, 0, 8'h77);
        drive(0, 0, 1, 8'h00);
        drive(1, 0, 1, a);
        drive(0, 1, 1, 8'h00);
        drive(0, 1, 1, 8'h00);
        drive(0, 1, 1, 8'h00);
        drive(0, 0, 1, 8'h00);
        check8("miss_hit", 8'(Hit), 8'h00);
        check8("miss_oe", Bus_Oe, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check8("rst_busy", 8'(Busy), 8'h01);
        check8("rst_oe", Bus_Oe, 8'h00);
        check8("rst_hit", 8'(Hit), 8'h00);
        check8("rst_out", Bus_Out, 8'h00);
        rst = 1'b0;
        wait_sweep();

        for (int a = 0; a < DEPTH; a++) begin
            do_read("clr", 8'(int'(BASE) + a), 8'h00);
        end

        do_write(8'h50, 8'hA5);
        do_read("rd_a5", 8'h50, 8'hA5);

        do_miss(8'h3F);
        do_miss(8'h80);
        do_read("edge_hi", 8'h7F, 8'h00);
        do_read("edge_lo", 8'h40, 8'h00);

        drive(1, 0, 1, 8'h50);
        drive(0, 1, 1, 8'h00);
        for (int i = 1; i < RL; i++) drive(0, 1, 1, 8'h00);
        drive(1, 1, 1, 8'h60);
        check8("abort_pre_oe", Bus_Oe, 8'hFF);
        check8("abort_pre_data", Bus_Out, 8'hA5);
        read_tail("abort", 8'h00);

        drive(1, 0, 1, 8'h51);
        drive(0, 1, 0, 8'h11);
        drive(0, 1, 0, 8'h22);
        drive(0, 1, 0, 8'h33);
        drive(0, 0, 1, 8'h00);
        do_read("multi_wr", 8'h51, 8'h11);

        drive(1, 0, 1, 8'h50);
        drive(0, 1, 1, 8'h00);
        for (int i = 1; i < RL; i++) drive(0, 1, 1, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        check8("rstdrv_pre_oe", Bus_Oe, 8'hFF);
        @(negedge clk);
        check8("rstdrv_oe", Bus_Oe, 8'h00);
        check8("rstdrv_busy", 8'(Busy), 8'h01);
        rst = 1'b0;
        wait_sweep();
        do_read("post_rst_50", 8'h50, 8'h00);
        do_read("post_rst_51", 8'h51, 8'h00);

        begin
            bit rw_cur;
            rw_cur = 1'b1;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                if (($urandom % 8) == 0) rw_cur = ~rw_cur;
                ALE    = (($urandom % 100) < 15);
                En     = (($urandom % 5) != 0);
                Rw     = rw_cur;
                Bus_In = ALE ? 8'($urandom_range(8'h30, 8'h90))
                             : 8'($urandom);
                rst    = (($urandom % 1500) == 0);
            end
            @(negedge clk);
            rst = 1'b0;
            ALE = 1'b0;
            En  = 1'b0;
            repeat (4) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
